config_port_arbiter: RTL and testbench

CONFIG_PORT_ARBITER -- requirements
Module: config_port_arbiter

---
 rtl/config_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_config_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/config_port_arbiter.sv
// Arbitrates three configuration-word sources (UART, bitbang, CPU) onto one
// registered write port feeding the configuration FSM.
//
// state    | meaning
// IDLE     | no owner; grants by priority UART > BB > CPU strobe
// OWN_UART | UART session owns the port until UART_Active drops
// OWN_BB   | bitbang session owns the port until BB_Active drops; not pre-emptible
// OWN_SELF | CPU owns the port; released on idle timeout or pre-empted by UART/BB
// HOLDOFF  | guard interval after any release; all strobes dropped
module config_port_arbiter #(
   parameter int unsigned IdleTimeout   = 16,
   parameter int unsigned HoldoffCycles = 2
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        UART_Active,
   input  logic [31:0] UART_WriteData,
   input  logic        UART_WriteStrobe,
   input  logic        BB_Active,
   input  logic [31:0] BB_WriteData,
   input  logic        BB_WriteStrobe,
   input  logic [31:0] SelfWriteData,
   input  logic        SelfWriteStrobe,
   output logic [31:0] ConfigWriteData,
   output logic        ConfigWriteStrobe,
   output logic        FSM_Reset,
   output logic [1:0]  Grant,
   output logic [7:0]  DroppedCount
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      OWN_UART = 3'd1,
      OWN_BB   = 3'd2,
      OWN_SELF = 3'd3,
      HOLDOFF  = 3'd4
   } state_t;

   localparam logic [7:0] IdleLoad = 8'(IdleTimeout - 1);
   localparam logic [7:0] HoldLoad = 8'(HoldoffCycles - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_data;
   logic        r_stb;
   logic        r_fsm_rst;
   logic [1:0]  r_grant;
   logic [7:0]  r_dropped;

   logic w_fwd_uart;
   logic w_fwd_bb;
   logic w_fwd_self;
   logic w_drop;

   // IDLE and OWN_SELF share the same priority resolution for the cycle's winner.
   always_comb begin
      w_fwd_uart = 1'b0;
      w_fwd_bb   = 1'b0;
      w_fwd_self = 1'b0;
      case (r_state)
         IDLE, OWN_SELF: begin
            w_fwd_uart = UART_Active & UART_WriteStrobe;
            w_fwd_bb   = ~UART_Active & BB_Active & BB_WriteStrobe;
            w_fwd_self = ~UART_Active & ~BB_Active & SelfWriteStrobe;
         end
         OWN_UART: w_fwd_uart = UART_WriteStrobe;
         OWN_BB:   w_fwd_bb   = BB_WriteStrobe;
         default: ;
      endcase
      w_drop = (UART_WriteStrobe & ~w_fwd_uart) |
               (BB_WriteStrobe   & ~w_fwd_bb)   |
               (SelfWriteStrobe  & ~w_fwd_self);
   end

   always_ff @(posedge CLK) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_data    <= 32'd0;
         r_stb     <= 1'b0;
         r_fsm_rst <= 1'b0;
         r_grant   <= 2'b00;
         r_dropped <= 8'd0;
      end else begin
         r_stb     <= w_fwd_uart | w_fwd_bb | w_fwd_self;
         r_fsm_rst <= 1'b0;
         if (w_fwd_uart)      r_data <= UART_WriteData;
         else if (w_fwd_bb)   r_data <= BB_WriteData;
         else if (w_fwd_self) r_data <= SelfWriteData;

         if (w_drop && r_dropped != 8'hFF)
            r_dropped <= r_dropped + 8'd1;

         case (r_state)
            IDLE, OWN_SELF: begin
               if (UART_Active) begin
                  r_state   <= OWN_UART;
                  r_grant   <= 2'b01;
                  r_fsm_rst <= 1'b1;
               end else if (BB_Active) begin
                  r_state   <= OWN_BB;
                  r_grant   <= 2'b10;
                  r_fsm_rst <= 1'b1;
               end else if (SelfWriteStrobe) begin
                  r_state <= OWN_SELF;
                  r_grant <= 2'b11;
                  r_cnt   <= IdleLoad;
               end else if (r_state == OWN_SELF) begin
                  // r_cnt counts down the remaining strobe-free cycles of this grant
                  if (r_cnt == 8'd0) begin
                     r_state <= HOLDOFF;
                     r_grant <= 2'b00;
                     r_cnt   <= HoldLoad;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            OWN_UART: begin
               if (!UART_Active) begin
                  r_state <= HOLDOFF;
                  r_grant <= 2'b00;
                  r_cnt   <= HoldLoad;
               end
            end
            OWN_BB: begin
               if (!BB_Active) begin
                  r_state <= HOLDOFF;
                  r_grant <= 2'b00;
                  r_cnt   <= HoldLoad;
               end
            end
            HOLDOFF: begin
               if (r_cnt == 8'd0) r_state <= IDLE;
               else               r_cnt   <= r_cnt - 8'd1;
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   assign ConfigWriteData   = r_data;
   assign ConfigWriteStrobe = r_stb;
   assign FSM_Reset         = r_fsm_rst;
   assign Grant             = r_grant;
   assign DroppedCount      = r_dropped;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: forwarded words go through a
// scoreboard queue, grant/reset/drop behaviour is checked against expectations.
module tb_config_port_arbiter;

   logic        CLK;
   logic        resetn;
   logic        UART_Active;
   logic [31:0] UART_WriteData;
   logic        UART_WriteStrobe;
   logic        BB_Active;
   logic [31:0] BB_WriteData;
   logic        BB_WriteStrobe;
   logic [31:0] SelfWriteData;
   logic        SelfWriteStrobe;
   logic [31:0] ConfigWriteData;
   logic        ConfigWriteStrobe;
   logic        FSM_Reset;
   logic [1:0]  Grant;
   logic [7:0]  DroppedCount;

   int          checks;
   int          failures;
   logic [31:0] sb[$];
   logic [31:0] last_data;
   int          exp_drop;

   config_port_arbiter #(.IdleTimeout(16), .HoldoffCycles(2)) dut (
      .CLK               (CLK),
      .resetn            (resetn),
      .UART_Active       (UART_Active),
      .UART_WriteData    (UART_WriteData),
      .UART_WriteStrobe  (UART_WriteStrobe),
      .BB_Active         (BB_Active),
      .BB_WriteData      (BB_WriteData),
      .BB_WriteStrobe    (BB_WriteStrobe),
      .SelfWriteData     (SelfWriteData),
      .SelfWriteStrobe   (SelfWriteStrobe),
      .ConfigWriteData   (ConfigWriteData),
      .ConfigWriteStrobe (ConfigWriteStrobe),
      .FSM_Reset         (FSM_Reset),
      .Grant             (Grant),
      .DroppedCount      (DroppedCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drop_one();
      if (exp_drop < 255) exp_drop++;
   endtask

   // One clock cycle: optionally push the word expected to be forwarded, then
   // compare the strobe/data the DUT presents after the edge.
   task automatic cyc(input logic fwd, input logic [31:0] d);
      logic in_rst;
      logic exp_stb;
      in_rst = ~resetn;
      if (fwd) sb.push_back(d);
      @(posedge CLK);
      #1;
      UART_WriteStrobe = 1'b0;
      BB_WriteStrobe   = 1'b0;
      SelfWriteStrobe  = 1'b0;
      if (in_rst) begin
         sb.delete();
         last_data = 32'd0;
      end
      exp_stb = (sb.size() > 0);
      chk("strobe", 32'(ConfigWriteStrobe), 32'(exp_stb));
      if (exp_stb) last_data = sb.pop_front();
      chk("data", ConfigWriteData, last_data);
   endtask

   initial begin
      checks = 0; failures = 0; last_data = 0; exp_drop = 0;
      resetn = 1'b0;
      UART_Active = 0; UART_WriteData = 0; UART_WriteStrobe = 0;
      BB_Active = 0; BB_WriteData = 0; BB_WriteStrobe = 0;
      SelfWriteData = 0; SelfWriteStrobe = 0;

      cyc(0, 0);
      cyc(0, 0);
      resetn = 1'b1;
      chk("rst_grant", 32'(Grant), 32'd0);
      chk("rst_fsm_reset", 32'(FSM_Reset), 32'd0);
      chk("rst_dropped", 32'(DroppedCount), 32'd0);

      // UART grant from IDLE with same-cycle strobe; losing BB strobe dropped
      UART_Active = 1; UART_WriteData = 32'hA5A5_0001; UART_WriteStrobe = 1;
      BB_WriteData = 32'h0000_0BAD; BB_WriteStrobe = 1; drop_one();
      cyc(1, 32'hA5A5_0001);
      chk("uart_grant", 32'(Grant), 32'd1);
      chk("uart_fsm_reset", 32'(FSM_Reset), 32'd1);
      chk("uart_dropped", 32'(DroppedCount), 32'(exp_drop));
      UART_WriteData = 32'h1111_1111; UART_WriteStrobe = 1;
      cyc(1, 32'h1111_1111);
      chk("uart_fsm_reset_once", 32'(FSM_Reset), 32'd0);
      chk("uart_grant_hold", 32'(Grant), 32'd1);
      // strobe in the cycle UART_Active drops is still forwarded
      UART_Active = 0; UART_WriteData = 32'h2222_2222; UART_WriteStrobe = 1;
      cyc(1, 32'h2222_2222);
      chk("uart_release", 32'(Grant), 32'd0);

      // HOLDOFF: exactly two cycles, strobes dropped, BB waits
      BB_Active = 1; SelfWriteData = 32'h33; SelfWriteStrobe = 1; drop_one();
      cyc(0, 0);
      chk("holdoff1_grant", 32'(Grant), 32'd0);
      chk("holdoff_dropped", 32'(DroppedCount), 32'(exp_drop));
      cyc(0, 0);
      chk("holdoff2_grant", 32'(Grant), 32'd0);
      BB_WriteData = 32'hB000_0001; BB_WriteStrobe = 1;
      SelfWriteData = 32'h44; SelfWriteStrobe = 1; drop_one();
      cyc(1, 32'hB000_0001);
      chk("bb_grant", 32'(Grant), 32'd2);
      chk("bb_fsm_reset", 32'(FSM_Reset), 32'd1);
      chk("bb_dropped", 32'(DroppedCount), 32'(exp_drop));

      // OWN_BB is not pre-empted by UART; UART strobes dropped
      UART_Active = 1;
      for (int i = 0; i < 3; i++) begin
         UART_WriteData = 32'hC000_0000 + 32'(i); UART_WriteStrobe = 1; drop_one();
         cyc(0, 0);
         chk("bb_no_preempt", 32'(Grant), 32'd2);
      end
      chk("bb_uart_dropped", 32'(DroppedCount), 32'(exp_drop));
      BB_WriteData = 32'hB000_0002; BB_WriteStrobe = 1;
      cyc(1, 32'hB000_0002);
      BB_Active = 0; UART_Active = 0;
      cyc(0, 0);
      chk("bb_release", 32'(Grant), 32'd0);
      cyc(0, 0);
      cyc(0, 0);

      // CPU grant, no FSM_Reset, idle timeout after 16 strobe-free cycles
      SelfWriteData = 32'h0000_00FF; SelfWriteStrobe = 1;
      cyc(1, 32'h0000_00FF);
      chk("self_grant", 32'(Grant), 32'd3);
      chk("self_no_fsm_reset", 32'(FSM_Reset), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 0);
         chk("self_timeout", 32'(Grant), (i < 16) ? 32'd3 : 32'd0);
      end
      cyc(0, 0);
      cyc(0, 0);
      SelfWriteData = 32'h0000_1234; SelfWriteStrobe = 1;
      cyc(1, 32'h0000_1234);
      chk("self_regrant", 32'(Grant), 32'd3);
      // a strobe mid-way restarts the idle count
      for (int i = 0; i < 10; i++) cyc(0, 0);
      SelfWriteData = 32'h55; SelfWriteStrobe = 1;
      cyc(1, 32'h55);
      for (int i = 0; i < 15; i++) cyc(0, 0);
      chk("self_count_cleared", 32'(Grant), 32'd3);

      // BB pre-empts CPU directly; same-cycle CPU word dropped
      BB_Active = 1; SelfWriteData = 32'hDEAD; SelfWriteStrobe = 1; drop_one();
      cyc(0, 0);
      chk("preempt_grant", 32'(Grant), 32'd2);
      chk("preempt_fsm_reset", 32'(FSM_Reset), 32'd1);
      chk("preempt_dropped", 32'(DroppedCount), 32'(exp_drop));

      // DroppedCount saturation
      UART_Active = 1;
      for (int i = 0; i < 300; i++) begin
         UART_WriteData = 32'(i); UART_WriteStrobe = 1; drop_one();
         cyc(0, 0);
      end
      chk("drop_saturate", 32'(DroppedCount), 32'(exp_drop));
      chk("drop_saturate_255", 32'(DroppedCount), 32'd255);

      // reset mid-session with a pending strobe
      resetn = 0; UART_WriteData = 32'h77; UART_WriteStrobe = 1;
      cyc(0, 0);
      chk("reset_grant", 32'(Grant), 32'd0);
      chk("reset_fsm_reset", 32'(FSM_Reset), 32'd0);
      chk("reset_dropped", 32'(DroppedCount), 32'd0);
      resetn = 1; UART_Active = 0; BB_Active = 0;
      cyc(0, 0);
      chk("post_reset_grant", 32'(Grant), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
